// File: rtl/shell_ctrl.sv
// shell_ctrl: controls the single shell fired by tank 0 in the 640x480 display.
// The raw fire button is synchronised and debounced. A press arms a pending
// launch, and the shell spawns at the tank muzzle on the next frame tick. The
// shell then advances once per frame, retires at the playfield border, and a
// cooldown runs before the next shell may fire. A registered per-pixel hit flag
// is also produced for the renderer.
//
// Ports:
//   i_clk_25m      pixel clock (single clock domain)
//   i_rst          asynchronous, active-high reset
//   i_frame_tick   one-cycle pulse per frame (vertical blanking)
//   i_fire_n       raw fire button, active low, asynchronous
//   i_tank_x/y     tank 0 top-left corner (30x30 sprite)
//   i_tank_dir     tank 0 direction: 0 up, 1 down, 2 left, 3 right
//   i_x_pos/y_pos  current pixel coordinate
//   i_valid        current pixel lies in the visible area
//   o_shell_active a shell is in flight
//   o_shell_x/y    shell top-left corner
//   o_shell_dir    shell travel direction
//   o_shell_pixel  previous cycle's pixel lies on the shell
//   o_fire_count   shells launched, wraps 255->0
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no shell; a pending press spawns on frame tick
// S_FLIGHT | shell moving one step per frame tick
// S_COOL   | shell retired; counting frames before re-arm
module shell_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SHELL_SIZE      = 4,
  parameter int SHELL_SPEED     = 4,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int X_MIN           = 2,
  parameter int X_MAX           = 638,
  parameter int Y_MIN           = 1,
  parameter int Y_MAX           = 478
) (
  input  logic       i_clk_25m,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_fire_n,
  input  logic [9:0] i_tank_x,
  input  logic [9:0] i_tank_y,
  input  logic [1:0] i_tank_dir,
  input  logic [9:0] i_x_pos,
  input  logic [9:0] i_y_pos,
  input  logic       i_valid,
  output logic       o_shell_active,
  output logic [9:0] o_shell_x,
  output logic [9:0] o_shell_y,
  output logic [1:0] o_shell_dir,
  output logic       o_shell_pixel,
  output logic [7:0] o_fire_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W = (COOLDOWN_FRAMES > 2) ? $clog2(COOLDOWN_FRAMES + 1) : 2;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES - 1);

  localparam logic [10:0] SPEED11   = 11'(SHELL_SPEED);
  localparam logic [10:0] SIZE11    = 11'(SHELL_SIZE);
  localparam logic [10:0] REACH11   = 11'(SHELL_SIZE - 1 + SHELL_SPEED);
  localparam logic [10:0] UP_LIM    = 11'(Y_MIN + SHELL_SPEED);
  localparam logic [10:0] LEFT_LIM  = 11'(X_MIN + SHELL_SPEED);
  localparam logic [10:0] X_MAX11   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLIGHT = 2'd1, S_COOL = 2'd2} state_t;

  state_t r_state, w_state_next;

  // input synchroniser and debouncer
  logic            r_fire_meta, r_fire_sync;
  logic            r_db_pressed;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;
  logic            w_sync_pressed;

  assign w_sync_pressed = ~r_fire_sync;

  always_ff @(posedge i_clk_25m or posedge i_rst) begin
    if (i_rst) begin
      r_fire_meta  <= 1'b1;
      r_fire_sync  <= 1'b1;
      r_db_pressed <= 1'b0;
      r_db_cnt     <= '0;
      r_press      <= 1'b0;
    end else begin
      r_fire_meta <= i_fire_n;
      r_fire_sync <= r_fire_meta;
      r_press     <= 1'b0;
      if (w_sync_pressed == r_db_pressed) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt     <= '0;
        r_db_pressed <= w_sync_pressed;
        r_press      <= w_sync_pressed;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // datapath registers
  logic            r_pending;
  logic [CD_W-1:0] r_cool;
  logic [9:0]      r_shell_x, r_shell_y;
  logic [1:0]      r_shell_dir;
  logic [7:0]      r_fire_count;
  logic            r_shell_pixel;

  logic        w_spawn, w_expire, w_cool_done, w_blocked;
  logic [10:0] w_tx, w_ty, w_sx, w_sy;
  logic [10:0] w_spawn_x, w_spawn_y, w_step_x, w_step_y;
  logic [10:0] w_dx, w_dy;
  logic        w_hit;

  assign w_tx = {1'b0, i_tank_x};
  assign w_ty = {1'b0, i_tank_y};
  assign w_sx = {1'b0, r_shell_x};
  assign w_sy = {1'b0, r_shell_y};

  always_comb begin
    w_spawn_x = w_tx;
    w_spawn_y = w_ty;
    case (i_tank_dir)
      2'd0: begin w_spawn_x = w_tx + 11'd13; w_spawn_y = w_ty;          end
      2'd1: begin w_spawn_x = w_tx + 11'd13; w_spawn_y = w_ty + 11'd26; end
      2'd2: begin w_spawn_x = w_tx;          w_spawn_y = w_ty + 11'd13; end
      default: begin w_spawn_x = w_tx + 11'd26; w_spawn_y = w_ty + 11'd13; end
    endcase
  end

  // a step is blocked when it would carry any shell pixel past the legal box
  always_comb begin
    w_step_x  = w_sx;
    w_step_y  = w_sy;
    w_blocked = 1'b0;
    case (r_shell_dir)
      2'd0: begin w_blocked = (w_sy < UP_LIM);              w_step_y = w_sy - SPEED11; end
      2'd1: begin w_blocked = (w_sy + REACH11 > Y_MAX11);   w_step_y = w_sy + SPEED11; end
      2'd2: begin w_blocked = (w_sx < LEFT_LIM);            w_step_x = w_sx - SPEED11; end
      default: begin w_blocked = (w_sx + REACH11 > X_MAX11); w_step_x = w_sx + SPEED11; end
    endcase
  end

  assign w_spawn     = (r_state == S_IDLE) && i_frame_tick && r_pending;
  assign w_expire    = (r_state == S_FLIGHT) && i_frame_tick && w_blocked;
  assign w_cool_done = (r_state == S_COOL) && i_frame_tick && (r_cool == CD_LAST);

  always_ff @(posedge i_clk_25m or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_spawn)     w_state_next = S_FLIGHT;
      S_FLIGHT: if (w_expire)    w_state_next = S_COOL;
      S_COOL:   if (w_cool_done) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_shell_active = (r_state == S_FLIGHT);
  end

  // unsigned 11-bit differences: a pixel left of / above the shell wraps to a
  // large value and so never satisfies the size compare
  assign w_dx  = {1'b0, i_x_pos} - w_sx;
  assign w_dy  = {1'b0, i_y_pos} - w_sy;
  assign w_hit = o_shell_active && i_valid && (w_dx < SIZE11) && (w_dy < SIZE11);

  always_ff @(posedge i_clk_25m or posedge i_rst) begin
    if (i_rst) begin
      r_pending     <= 1'b0;
      r_cool        <= '0;
      r_shell_x     <= '0;
      r_shell_y     <= '0;
      r_shell_dir   <= '0;
      r_fire_count  <= '0;
      r_shell_pixel <= 1'b0;
    end else begin
      r_shell_pixel <= w_hit;
      // presses outside IDLE are dropped, never queued
      if (w_spawn)
        r_pending <= 1'b0;
      else if (r_press && (r_state == S_IDLE))
        r_pending <= 1'b1;

      if (w_spawn) begin
        r_shell_x    <= w_spawn_x[9:0];
        r_shell_y    <= w_spawn_y[9:0];
        r_shell_dir  <= i_tank_dir;
        r_fire_count <= r_fire_count + 8'd1;
      end else if ((r_state == S_FLIGHT) && i_frame_tick && !w_blocked) begin
        r_shell_x <= w_step_x[9:0];
        r_shell_y <= w_step_y[9:0];
      end

      if (w_expire)
        r_cool <= '0;
      else if ((r_state == S_COOL) && i_frame_tick)
        r_cool <= r_cool + 1'b1;
    end
  end

  assign o_shell_x     = r_shell_x;
  assign o_shell_y     = r_shell_y;
  assign o_shell_dir   = r_shell_dir;
  assign o_shell_pixel = r_shell_pixel;
  assign o_fire_count  = r_fire_count;

endmodule

// File: tb/tb_shell_ctrl.sv
module tb_shell_ctrl;
  localparam int DB    = 8;
  localparam int SIZE  = 4;
  localparam int SPEED = 4;
  localparam int COOL  = 15;
  localparam int X_MIN = 2;
  localparam int X_MAX = 638;
  localparam int Y_MIN = 1;
  localparam int Y_MAX = 478;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       fire_n = 1'b1;
  logic [9:0] tx = '0, ty = '0;
  logic [1:0] tdir = '0;
  logic [9:0] xp = '0, yp = '0;
  logic       vld = 1'b0;

  logic       active;
  logic [9:0] sx_o, sy_o;
  logic [1:0] sdir_o;
  logic       pix;
  logic [7:0] cnt;

  shell_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk_25m(clk), .i_rst(rst), .i_frame_tick(tick), .i_fire_n(fire_n),
    .i_tank_x(tx), .i_tank_y(ty), .i_tank_dir(tdir),
    .i_x_pos(xp), .i_y_pos(yp), .i_valid(vld),
    .o_shell_active(active), .o_shell_x(sx_o), .o_shell_y(sy_o),
    .o_shell_dir(sdir_o), .o_shell_pixel(pix), .o_fire_count(cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    fire_n = 1'b1; tick = 1'b0; vld = 1'b0;
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask

  task automatic press();
    fire_n = 1'b0; cyc(DB + 3);
    fire_n = 1'b1; cyc(DB + 6);
  endtask

  task automatic frame();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
  endtask

  // reference model: muzzle position and how far a shell can travel
  function automatic void spawn_of(input int x, input int y, input int d, output int ox, output int oy);
    case (d)
      0: begin ox = x + 13; oy = y;      end
      1: begin ox = x + 13; oy = y + 26; end
      2: begin ox = x;      oy = y + 13; end
      default: begin ox = x + 26; oy = y + 13; end
    endcase
  endfunction

  function automatic int max_steps(input int x, input int y, input int d);
    case (d)
      0: return (y >= Y_MIN) ? (y - Y_MIN) / SPEED : 0;
      1: return (y <= Y_MAX - SIZE + 1) ? (Y_MAX - SIZE + 1 - y) / SPEED : 0;
      2: return (x >= X_MIN) ? (x - X_MIN) / SPEED : 0;
      default: return (x <= X_MAX - SIZE + 1) ? (X_MAX - SIZE + 1 - x) / SPEED : 0;
    endcase
  endfunction

  function automatic void pos_after(input int x, input int y, input int d, input int k,
                                    output int ex, output int ey, output int act);
    int ms, n;
    ms  = max_steps(x, y, d);
    n   = (k < ms) ? k : ms;
    act = (k <= ms) ? 1 : 0;
    ex  = x + ((d == 3) ? SPEED * n : (d == 2) ? -SPEED * n : 0);
    ey  = y + ((d == 1) ? SPEED * n : (d == 0) ? -SPEED * n : 0);
  endfunction

  typedef struct {
    int tx; int ty; int dir; int exp_x; int exp_y;
  } vec_t;

  vec_t vecs[5];

  task automatic launch(input int x, input int y, input int d);
    tx = 10'(x); ty = 10'(y); tdir = 2'(d);
    press();
    frame();
  endtask

  initial begin
    int ex, ey, ea, sx, sy, d, ms, k, hits;

    vecs[0] = '{100, 200, 3, 126, 213};
    vecs[1] = '{300,   1, 0, 313,   1};
    vecs[2] = '{ 50,  60, 1,  63,  86};
    vecs[3] = '{400, 240, 2, 400, 253};
    vecs[4] = '{  0,   0, 2,   0,  13};

    // reset state
    do_reset();
    check("rst_active", active, 0);
    check("rst_x", sx_o, 0);
    check("rst_y", sy_o, 0);
    check("rst_dir", sdir_o, 0);
    check("rst_pixel", pix, 0);
    check("rst_count", cnt, 0);

    // clean press: no launch before the tick, exactly one at the tick
    tx = 10'd100; ty = 10'd200; tdir = 2'd3;
    press();
    check("press_no_early", active, 0);
    frame();
    check("press_launch", active, 1);
    check("press_count", cnt, 1);
    frame();
    check("press_single_count", cnt, 1);
    check("press_moved_x", sx_o, 130);

    // bouncing button never produces a launch
    do_reset();
    for (int i = 0; i < 14; i++) begin
      fire_n = ~fire_n; cyc(3);
    end
    fire_n = 1'b1; cyc(20);
    frame();
    check("bounce_active", active, 0);
    check("bounce_count", cnt, 0);

    // table of spawn positions
    foreach (vecs[i]) begin
      do_reset();
      launch(vecs[i].tx, vecs[i].ty, vecs[i].dir);
      check($sformatf("vec%0d_active", i), active, 1);
      check($sformatf("vec%0d_x", i), sx_o, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), sy_o, vecs[i].exp_y);
      check($sformatf("vec%0d_dir", i), sdir_o, vecs[i].dir);
    end

    // full flight to the right border; tank turns mid-flight
    do_reset();
    launch(100, 200, 3);
    for (int k2 = 1; k2 <= 128; k2++) begin
      if (k2 == 50) tdir = 2'd0;
      frame();
      pos_after(126, 213, 3, k2, ex, ey, ea);
      check($sformatf("right_x_k%0d", k2), sx_o, ex);
      check($sformatf("right_act_k%0d", k2), active, ea);
    end
    check("right_dir_kept", sdir_o, 3);
    check("right_y_held", sy_o, 213);

    // top edge: immediate expiry, then exact cooldown length
    do_reset();
    launch(300, 1, 0);
    check("up_spawn_x", sx_o, 313);
    check("up_spawn_y", sy_o, 1);
    frame();
    check("up_expired", active, 0);
    check("up_y_held", sy_o, 1);
    for (int t = 1; t <= COOL; t++) begin
      if (t == 10 || t == COOL) press();
      frame();
      check($sformatf("cool_t%0d_inactive", t), active, 0);
    end
    frame();
    check("cool_press_dropped", active, 0);
    check("cool_count", cnt, 1);
    press();
    frame();
    check("after_cool_launch", active, 1);
    check("after_cool_count", cnt, 2);

    // per-pixel hit flag around a shell at (200,100)
    do_reset();
    launch(187, 104, 0);
    frame();
    check("pix_shell_x", sx_o, 200);
    check("pix_shell_y", sy_o, 100);
    for (int v = 1; v >= 0; v--) begin
      hits = 0;
      for (int y = 99; y <= 104; y++) begin
        for (int x = 199; x <= 204; x++) begin
          xp = 10'(x); yp = 10'(y); vld = v[0];
          cyc(1);
          ea = (v == 1 && x >= 200 && x < 200 + SIZE && y >= 100 && y < 100 + SIZE) ? 1 : 0;
          if (pix === 1'b1) hits++;
          check($sformatf("pix_v%0d_%0d_%0d", v, x, y), pix, ea);
        end
      end
      check($sformatf("pix_hits_v%0d", v), hits, (v == 1) ? 16 : 0);
    end
    vld = 1'b0;

    // asynchronous reset mid-flight
    do_reset();
    launch(387, 244, 0);
    frame();
    check("mid_x", sx_o, 400);
    check("mid_y", sy_o, 240);
    #2 rst = 1'b1;
    #1;
    check("async_active", active, 0);
    check("async_x", sx_o, 0);
    check("async_y", sy_o, 0);
    check("async_count", cnt, 0);
    cyc(1); rst = 1'b0; cyc(2);
    frame();
    check("post_rst_no_spawn", active, 0);
    check("post_rst_count", cnt, 0);

    // randomized trials against the reference model
    for (int trial = 0; trial < 20; trial++) begin
      do_reset();
      d = $urandom_range(0, 3);
      launch($urandom_range(0, 610), $urandom_range(0, 450), d);
      spawn_of(int'(tx), int'(ty), d, sx, sy);
      check($sformatf("rnd%0d_sx", trial), sx_o, sx);
      check($sformatf("rnd%0d_sy", trial), sy_o, sy);
      check($sformatf("rnd%0d_dir", trial), sdir_o, d);
      check($sformatf("rnd%0d_count", trial), cnt, 1);
      ms = max_steps(sx, sy, d);
      k  = $urandom_range(0, ms + 2);
      for (int j = 1; j <= k; j++) begin
        if (j == k / 2) tdir = 2'($urandom_range(0, 3));
        frame();
        pos_after(sx, sy, d, j, ex, ey, ea);
        check($sformatf("rnd%0d_x_k%0d", trial, j), sx_o, ex);
        check($sformatf("rnd%0d_y_k%0d", trial, j), sy_o, ey);
        check($sformatf("rnd%0d_act_k%0d", trial, j), active, ea);
      end
      check($sformatf("rnd%0d_dir_end", trial), sdir_o, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
